// File: rtl/mem_responder.sv
// Memory responder: preloaded from a streaming loader, then serves CPU
// reads (one-cycle registered latency) and writes until the next reset.
module mem_responder #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] mem,
   input  logic                  ld_valid,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  ld_last,
   output logic                  ld_ready,
   output logic                  busy,
   output logic [ADDR_WIDTH:0]   loaded,
   output logic                  wr_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {S_LOAD, S_RUN} state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH:0]   r_loaded;
   logic [DATA_WIDTH-1:0] r_mem;
   logic                  r_wr_err;
   logic                  r_ld_ready;
   logic                  r_busy;
   logic [DATA_WIDTH-1:0] r_array [DEPTH];

   logic w_ld_hs;
   logic w_ld_end;
   logic w_cpu_wr;

   // A loader word is taken only while loading; the load ends on the
   // marked last word or on the word that fills the top address.
   assign w_ld_hs  = ld_valid & r_ld_ready & (r_state == S_LOAD);
   assign w_ld_end = w_ld_hs & (ld_last | (&r_ptr));
   assign w_cpu_wr = we & (r_state == S_RUN);

   // Control FSM with registered outputs; read data is captured here so
   // it is cleared by reset and held at zero during the load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_LOAD;
         r_ptr      <= '0;
         r_loaded   <= '0;
         r_mem      <= '0;
         r_wr_err   <= 1'b0;
         r_ld_ready <= 1'b1;
         r_busy     <= 1'b1;
      end else begin
         case (r_state)
            S_LOAD: begin
               r_mem <= '0;
               if (we) r_wr_err <= 1'b1;
               if (w_ld_hs) begin
                  r_ptr    <= r_ptr + 1'b1;
                  r_loaded <= r_loaded + 1'b1;
               end
               if (w_ld_end) begin
                  r_state    <= S_RUN;
                  r_ld_ready <= 1'b0;
                  r_busy     <= 1'b0;
               end
            end
            S_RUN: begin
               // Old contents are returned on a same-address write edge.
               r_mem <= r_array[addr];
            end
            default: begin
               r_state <= S_LOAD;
            end
         endcase
      end
   end

   // Storage array: never cleared; writes are suppressed while reset is low.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (w_ld_hs)
            r_array[r_ptr] <= ld_data;
         else if (w_cpu_wr)
            r_array[addr] <= data;
      end
   end

   assign mem      = r_mem;
   assign ld_ready = r_ld_ready;
   assign busy     = r_busy;
   assign loaded   = r_loaded;
   assign wr_err   = r_wr_err;

endmodule
